// File: rtl/orv64_itb_reader.sv
// ORV64 instruction trace buffer reader.
//
// Drains a frozen trace buffer through its debug-access port. It streams every valid entry
// oldest-first on a valid/ready interface and marks the newest entry with out_last.
// On start it snapshots the buffer's last-written pointer and wrap flag. Each entry then takes
// three cycles:
//   RD  -> drive a RAM read
//   CAP -> register the read data
//   OUT -> hold it until the consumer accepts it
//
// Optional build macro ORV64_ITB_RD_CLEAR_EN enables read-and-clear. Each entry is zeroed in
// the CAP cycle, immediately after its data has been captured.

module orv64_itb_reader #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 39
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] itb_last_ptr,
  input  logic              itb_wrapped,
  input  logic              itb_empty,
  output logic              dbg_en,
  output logic              dbg_rw,
  output logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_din,
  input  logic [DATA_W-1:0] dbg_dout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StCap,
    StOut,
    StFin
  } state_e;

  localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CntOne  = (ADDR_W + 1)'(1);
  // A wrapped buffer holds the full 2^ADDR_W entries.
  localparam logic [ADDR_W:0]   CntFull = {1'b1, {ADDR_W{1'b0}}};

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [ADDR_W:0]     remaining_q, remaining_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_last_q, out_last_d;

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rd_addr_q   <= '0;
      remaining_q <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      remaining_q <= remaining_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  // Next-state logic: pointer snapshot, per-entry read/capture/handshake, and abort.
  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    remaining_d = remaining_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;

    unique case (state_q)
      StIdle: begin
        // Start takes priority over a simultaneous abort; abort alone is ignored here.
        if (start) begin
          if (itb_empty) begin
            state_d = StFin;
          end else begin
            if (itb_wrapped) begin
              // Oldest entry sits just after the newest one.
              rd_addr_d   = itb_last_ptr + AddrOne;
              remaining_d = CntFull;
            end else begin
              rd_addr_d   = '0;
              remaining_d = {1'b0, itb_last_ptr} + CntOne;
            end
            state_d = StRd;
          end
        end
      end

      StRd: begin
        if (abort) begin
          state_d = StFin;
        end else begin
          state_d = StCap;
        end
      end

      StCap: begin
        // On abort the read in flight is dropped and the output register is left alone.
        if (abort) begin
          state_d = StFin;
        end else begin
          out_data_d  = dbg_dout;
          out_last_d  = (remaining_q == CntOne);
          rd_addr_d   = rd_addr_q + AddrOne;
          remaining_d = remaining_q - CntOne;
          state_d     = StOut;
        end
      end

      StOut: begin
        if (abort) begin
          state_d = StFin;
        end else if (out_ready) begin
          if (remaining_q == '0) begin
            state_d = StFin;
          end else begin
            state_d = StRd;
          end
        end
      end

      StFin: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Decoded outputs: trace RAM port, stream handshake and status.
  always_comb begin
    dbg_en   = 1'b0;
    dbg_rw   = 1'b0;
    dbg_addr = '0;
    dbg_din  = '0;

    if (state_q == StRd) begin
      dbg_en   = 1'b1;
      dbg_addr = rd_addr_q;
    end

`ifdef ORV64_ITB_RD_CLEAR_EN
    // rd_addr_q still points at the entry being captured.
    // An aborted capture skips the clear, so uncaptured entries survive.
    if (state_q == StCap && !abort) begin
      dbg_en   = 1'b1;
      dbg_rw   = 1'b1;
      dbg_addr = rd_addr_q;
    end
`endif

    out_valid = (state_q == StOut);
    busy      = (state_q != StIdle);
    done      = (state_q == StFin);
  end

  assign out_data = out_data_q;
  assign out_last = out_last_q;

endmodule

// File: tb/tb_orv64_itb_reader.sv
// Testbench for orv64_itb_reader.
// A behavioural trace RAM drives the read port. A scoreboard queue holds the expected beats.

module tb_orv64_itb_reader;

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 39;
  localparam int unsigned DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst, start, abort, itb_wrapped, itb_empty;
  logic [AW-1:0] itb_last_ptr;
  logic          dbg_en, dbg_rw;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_din, dbg_dout;
  logic          out_valid, out_ready, out_last, busy, done;
  logic [DW-1:0] out_data;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  logic [DW-1:0] mem    [DEPTH];
  logic [DW-1:0] golden [DEPTH];
  logic          init_req;

  int tests = 0, failed = 0, cycle = 0;
  int hs_count = 0, last_hs_cycle = 0, done_count = 0, done_cycle = 0;
  int rd_count = 0, wr_count = 0;
  int h0, r0, d0, w0;

  logic          pv = 1'b0, pr = 1'b0, pa = 1'b0, prst = 1'b1, pl = 1'b0;
  logic [DW-1:0] pd = '0;

  always #5 clk = ~clk;

  orv64_itb_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .itb_last_ptr (itb_last_ptr),
    .itb_wrapped  (itb_wrapped),
    .itb_empty    (itb_empty),
    .dbg_en       (dbg_en),
    .dbg_rw       (dbg_rw),
    .dbg_addr     (dbg_addr),
    .dbg_din      (dbg_din),
    .dbg_dout     (dbg_dout),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done)
  );

  // Trace RAM model: read data appears the cycle after a read.
  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= DW'(32'h100 + i);
    end else if (dbg_en && dbg_rw) begin
      mem[dbg_addr] <= dbg_din;
    end
    if (dbg_en && !dbg_rw) dbg_dout <= mem[dbg_addr];
  end

  always @(posedge clk) cycle <= cycle + 1;

  function automatic void check(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  // Monitor: checks stream stability and scoreboard beats, and counts RAM accesses.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && pv && !pr && !pa && !prst) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_data", 64'(out_data), 64'(pd));
        check("stall_last", 64'(out_last), 64'(pl));
      end
      if (!rst && out_valid && out_ready) begin
        hs_count++;
        last_hs_cycle = cycle;
        if (sb.size() == 0) begin
          check("extra_beat", 64'd0, 64'd1);
        end else begin
          mon_e = sb.pop_front();
          check("beat_data", 64'(out_data), 64'(mon_e.data));
          check("beat_last", 64'(out_last), 64'(mon_e.last));
        end
      end
      if (done) begin
        done_count++;
        done_cycle = cycle;
      end
      if (dbg_en && !dbg_rw) rd_count++;
      if (dbg_en && dbg_rw) begin
        wr_count++;
        check("clr_din", 64'(dbg_din), 64'd0);
      end
`ifndef ORV64_ITB_RD_CLEAR_EN
      if (dbg_rw || dbg_din != '0) check("rw_tied", 64'({dbg_rw, dbg_din}), 64'd0);
`endif
      pv = out_valid; pr = out_ready; pa = abort; prst = rst; pd = out_data; pl = out_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_ram();
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    for (int i = 0; i < DEPTH; i++) golden[i] = DW'(32'h100 + i);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, 64'(seen), 64'd1);
  endtask

  task automatic wait_valid(string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check(tag, 64'(seen), 64'd1);
  endtask

  function automatic void push_drain(logic wr, logic [AW-1:0] lp);
    logic [AW-1:0] a;
    int n;
    if (wr) begin
      a = lp + AW'(1);
      n = DEPTH;
    end else begin
      a = '0;
      n = int'(lp) + 1;
    end
    for (int k = 0; k < n; k++) begin
      sb.push_back('{data: golden[a], last: (k == n - 1)});
      a = a + AW'(1);
    end
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; itb_wrapped = 1'b0; itb_empty = 1'b0;
    itb_last_ptr = '0; out_ready = 1'b0; init_req = 1'b0;
    init_ram();
    tick();
    tick();
    check("rst_flags", 64'({busy, done, out_valid, dbg_en, dbg_rw, out_last}), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_addr", 64'(dbg_addr), 64'd0);
    rst = 1'b0;
    tick();

    // Abort while idle has no effect.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("idle_abort", 64'({busy, done}), 64'd0);

    // Unwrapped drain of 6 entries, with latency checks.
    // A second start and a pointer change land mid-drain; both must be ignored.
    out_ready = 1'b1; itb_last_ptr = 4'd5; itb_wrapped = 1'b0;
    push_drain(1'b0, 4'd5);
    h0 = hs_count; r0 = rd_count; d0 = done_count;
    start = 1'b1;
    tick();
    check("lat_rd", 64'({busy, dbg_en, dbg_rw, out_valid}), 64'b1100);
    check("rd_addr0", 64'(dbg_addr), 64'd0);
    itb_last_ptr = 4'd2;
    tick();
    start = 1'b0;
    check("lat_cap", 64'(out_valid), 64'd0);
    tick();
    check("lat_out", 64'(out_valid), 64'd1);
    wait_done("t1_done");
    tick();
    check("t1_idle", 64'({busy, done}), 64'd0);
    check("t1_beats", 64'(hs_count - h0), 64'd6);
    check("t1_done_lat", 64'(done_cycle), 64'(last_hs_cycle + 1));
    check("t1_sb", 64'(sb.size()), 64'd0);
    check("t1_reads", 64'(rd_count - r0), 64'd6);
    check("t1_done_once", 64'(done_count - d0), 64'd1);

    // Wrapped drain; start and abort in the same idle cycle, so start wins.
    init_ram();
    itb_wrapped = 1'b1; itb_last_ptr = 4'd9;
    push_drain(1'b1, 4'd9);
    h0 = hs_count;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("start_wins", 64'({busy, done}), 64'b10);
    check("wrap_addr", 64'(dbg_addr), 64'd10);
    wait_done("t2_done");
    tick();
    check("t2_beats", 64'(hs_count - h0), 64'd16);
    check("t2_sb", 64'(sb.size()), 64'd0);

    // Empty buffer: finish at once, with no reads.
    itb_empty = 1'b1; itb_wrapped = 1'b0;
    r0 = rd_count;
    pulse_start();
    check("empty_fin", 64'({busy, done, out_valid}), 64'b110);
    tick();
    check("empty_idle", 64'({busy, done}), 64'd0);
    check("empty_reads", 64'(rd_count - r0), 64'd0);
    itb_empty = 1'b0;

    // Backpressure on the second beat for 5 cycles.
    init_ram();
    itb_last_ptr = 4'd5; out_ready = 1'b0;
    push_drain(1'b0, 4'd5);
    h0 = hs_count;
    pulse_start();
    wait_valid("t4_v1");
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    wait_valid("t4_v2");
    r0 = rd_count;
    repeat (5) tick();
    check("t4_noread", 64'(rd_count - r0), 64'd0);
    check("t4_hold", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    wait_done("t4_done");
    tick();
    check("t4_beats", 64'(hs_count - h0), 64'd6);
    check("t4_sb", 64'(sb.size()), 64'd0);

    // Abort during the third beat's OUT, then replay the drain.
    init_ram();
    out_ready = 1'b0;
    push_drain(1'b0, 4'd5);
    pulse_start();
    for (int b = 0; b < 2; b++) begin
      wait_valid("t5_v");
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    wait_valid("t5_v3");
    d0 = done_count;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_drop", 64'({out_valid, done, busy}), 64'b011);
    tick();
    check("abort_idle", 64'({busy, done, out_valid}), 64'd0);
    tick();
    check("abort_done_once", 64'(done_count - d0), 64'd1);
    check("abort_left", 64'(sb.size()), 64'd4);
    sb.delete();
`ifdef ORV64_ITB_RD_CLEAR_EN
    for (int i = 0; i < 3; i++) golden[i] = '0;
`endif
    out_ready = 1'b1;
    push_drain(1'b0, 4'd5);
    pulse_start();
    wait_done("t5_done");
    tick();
    check("t5_sb", 64'(sb.size()), 64'd0);

    // Reset in mid-drain: outputs clear, and no done pulse follows.
    init_ram();
    out_ready = 1'b0;
    push_drain(1'b0, 4'd5);
    pulse_start();
    wait_valid("t6_v");
    d0 = done_count;
    rst = 1'b1;
    tick();
    check("rst_mid", 64'({busy, done, out_valid, dbg_en, out_last}), 64'd0);
    check("rst_mid_data", 64'(out_data), 64'd0);
    rst = 1'b0;
    repeat (3) tick();
    check("rst_nodone", 64'(done_count - d0), 64'd0);
    sb.delete();

`ifdef ORV64_ITB_RD_CLEAR_EN
    // Read-and-clear: drain 4 entries, then drain again and expect zeros.
    init_ram();
    out_ready = 1'b1; itb_last_ptr = 4'd3;
    w0 = wr_count;
    push_drain(1'b0, 4'd3);
    pulse_start();
    wait_done("t7_done");
    tick();
    check("clr_writes", 64'(wr_count - w0), 64'd4);
    for (int i = 0; i < 4; i++) check("clr_mem", 64'(mem[i]), 64'd0);
    check("clr_keep", 64'(mem[4]), 64'h104);
    for (int i = 0; i < 4; i++) golden[i] = '0;
    push_drain(1'b0, 4'd3);
    pulse_start();
    wait_done("t7_done2");
    tick();
    check("t7_sb", 64'(sb.size()), 64'd0);
`else
    w0 = 0;
    check("no_writes", 64'(wr_count - w0), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
